pattern_sequence_generator: RTL and testbench
=============================================

Name: pattern_sequence_generator

Overview:
Serial transmitter for the 5-bit pattern set recognised by the team's sequence detector. It emits the selected pattern MSB-first on a 1-bit line, repeated a programmable number of times with a programmable idle gap between frames. Typical use is as the stimulus source that drives a detector's serial input, or as a pattern beacon toward an external receiver on the FPGA.

Parameters:
GAP_BIT, 1'b0, line value driven while idle, in gaps, and after reset
CNT_W, 16, width of frames_sent

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high
start  in  1  request; sampled only in IDLE
abort  in  1  cancel the transfer in progress
pattern_sel  in  2  pattern select, latched at accepted start
repeat_count  in  8  frames to send, latched at accepted start
gap_len  in  4  idle cycles between frames, latched at accepted start
serial_out  out  1  serial data line
serial_valid  out  1  high while serial_out carries a pattern bit
busy  out  1  transfer in progress
done  out  1  one-cycle pulse on normal completion
frames_sent  out  CNT_W  completed-frame counter

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Pattern table, sent bit4 first:
  - 00 = 10111
  - 01 = 01010
  - 10 = 10101
  - 11 = 10100
- All outputs are registered.
- Reset values:
  - serial_out = GAP_BIT
  - serial_valid = 0
  - busy = 0
  - done = 0
  - frames_sent = 0
  - FSM = IDLE
  - latched pattern = 00
- Reset applies on any cycle, including mid-frame. It takes priority over abort and start.
- FSM states: IDLE, SHIFT, GAP, DONE.
- IDLE:
  - start=1 latches pattern_sel, repeat_count and gap_len.
  - If the new pattern_sel differs from the previously latched one, frames_sent clears in the same cycle.
  - If repeat_count = 0, go to DONE.
  - Otherwise load the shift register, set bit index = 4 and frame counter = repeat_count, and go to SHIFT.
- SHIFT (5 cycles per frame):
  - serial_out = current bit, serial_valid = 1, busy = 1.
  - On bit index 0:
    - frames_sent increments, saturating at all-ones.
    - Frame counter decrements.
    - If it reaches 0, go to DONE.
    - Else if gap_len = 0, reload and stay in SHIFT, giving back-to-back frames.
    - Else go to GAP.
- GAP:
  - serial_out = GAP_BIT, serial_valid = 0, busy = 1, for exactly gap_len cycles.
  - Then reload and enter SHIFT.
  - No gap follows the last frame.
- DONE: one cycle with done = 1, busy = 0, serial_out = GAP_BIT, serial_valid = 0. Then go to IDLE. start is ignored in DONE.
- Latency: with start accepted at cycle T and N > 0:
  - The first bit appears at T+1.
  - The last bit is at T+5N+G(N-1).
  - done pulses the following cycle.
  - For N = 0, done pulses at T+1 and no valid bits are sent.
- start while busy or in DONE is ignored; latched inputs are never re-sampled mid-transfer.
- abort in SHIFT or GAP:
  - Next cycle is IDLE with serial_out = GAP_BIT, serial_valid = 0, busy = 0.
  - No done pulse.
  - frames_sent keeps the frames already completed; a partial frame is not counted.
- abort in IDLE or DONE has no effect.
- abort and start in the same IDLE cycle: start wins (abort is ignored in IDLE).
- Input changes on pattern_sel, repeat_count or gap_len while busy have no effect until the next accepted start.

Decomposition:
- Shared package seq_pkg holds:
  - The pattern width constant (5).
  - The 4-entry pattern table constants.
  - The state encoding constants.
- The detector is updated to use the same package so both ends agree.
- One natural sub-module: pattern_rom (2-bit select to 5-bit pattern, combinational).
- FSM, shift register and counters stay in the top.

Test Plan:
- Reset, then start with pattern_sel=00, repeat_count=1, gap_len=0 -> serial_out 1,0,1,1,1 at T+1..T+5 with serial_valid=1; done=1 at T+6; frames_sent=1.
- pattern_sel=10, repeat_count=3, gap_len=2 -> three 10101 frames with 2 cycles of serial_valid=0/GAP_BIT between them; last bit at T+19; done at T+20; frames_sent=3. Loop serial_out into the detector set to 10 -> 3 detections.
- pattern_sel=01, repeat_count=4, gap_len=0 -> 20 contiguous valid bits 01010 x4; busy high T+1..T+20; done at T+21.
- Abort at the 3rd bit of frame 2 (repeat_count=5) -> IDLE next cycle; busy=0; no done pulse; frames_sent=1. Then start with the same pattern_sel and repeat_count=1 -> frames_sent=2.
- Start with pattern_sel=11 after prior pattern_sel=01 -> frames_sent clears to 0, then counts to repeat_count. Also check repeat_count=0 -> done at T+1 with no valid bits.
- Reset asserted mid-GAP, and start pulses while busy -> reset forces all reset values next cycle; start while busy causes no re-latch and no timing change.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern generator and detector.
// Pattern width, pattern table and FSM state encoding.
package seq_pkg;

  localparam int PAT_W = 5;

  localparam logic [PAT_W-1:0] PAT_0 = 5'b10111;
  localparam logic [PAT_W-1:0] PAT_1 = 5'b01010;
  localparam logic [PAT_W-1:0] PAT_2 = 5'b10101;
  localparam logic [PAT_W-1:0] PAT_3 = 5'b10100;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/pattern_rom.sv
// Pattern table lookup: 2-bit select to 5-bit pattern.
// Purely combinational.
module pattern_rom
  import seq_pkg::*;
(
  input  logic [1:0]       sel,
  output logic [PAT_W-1:0] pattern
);

  // Table decode
  always_comb begin
    pattern = PAT_0;
    unique case (sel)
      2'b00: pattern = PAT_0;
      2'b01: pattern = PAT_1;
      2'b10: pattern = PAT_2;
      2'b11: pattern = PAT_3;
    endcase
  end

endmodule

// File: rtl/pattern_sequence_generator.sv
// Serial pattern transmitter: MSB-first frames, repeat count,
// programmable idle gap. All outputs registered.
module pattern_sequence_generator
  import seq_pkg::*;
#(
  parameter logic GAP_BIT = 1'b0,
  parameter int   CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       pattern_sel,
  input  logic [7:0]       repeat_count,
  input  logic [3:0]       gap_len,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] frames_sent
);

  state_t             state, state_n;
  logic [1:0]         pat_q, pat_n;
  logic [PAT_W-1:0]   shreg, shreg_n;
  logic [2:0]         bit_idx, idx_n;
  logic [7:0]         frame_cnt, frame_n;
  logic [3:0]         gap_q, gap_n;
  logic [3:0]         gap_cnt, gcnt_n;
  logic [CNT_W-1:0]   frames_n;
  logic               out_n, valid_n, busy_n, done_n;
  logic [1:0]         rom_sel;
  logic [PAT_W-1:0]   rom_pat;

  // New select is looked up at start; latched one on reload
  assign rom_sel = (state == S_IDLE) ? pattern_sel : pat_q;

  pattern_rom u_rom (
    .sel     (rom_sel),
    .pattern (rom_pat)
  );

  // Next-state, datapath and next-output logic
  always_comb begin
    state_n  = state;
    pat_n    = pat_q;
    shreg_n  = shreg;
    idx_n    = bit_idx;
    frame_n  = frame_cnt;
    gap_n    = gap_q;
    gcnt_n   = gap_cnt;
    frames_n = frames_sent;
    out_n    = GAP_BIT;
    valid_n  = 1'b0;
    busy_n   = 1'b0;
    done_n   = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          pat_n = pattern_sel;
          gap_n = gap_len;
          if (pattern_sel != pat_q)
            frames_n = '0;
          if (repeat_count == 8'd0) begin
            state_n = S_DONE;
            done_n  = 1'b1;
          end else begin
            state_n = S_SHIFT;
            shreg_n = rom_pat;
            idx_n   = 3'd4;
            frame_n = repeat_count;
            out_n   = rom_pat[PAT_W-1];
            valid_n = 1'b1;
            busy_n  = 1'b1;
          end
        end
      end

      S_SHIFT: begin
        if (abort) begin
          state_n = S_IDLE;
        end else if (bit_idx == 3'd0) begin
          if (frames_sent != '1)
            frames_n = frames_sent + 1'b1;
          frame_n = frame_cnt - 8'd1;
          if (frame_cnt == 8'd1) begin
            state_n = S_DONE;
            done_n  = 1'b1;
          end else if (gap_q == 4'd0) begin
            shreg_n = rom_pat;
            idx_n   = 3'd4;
            out_n   = rom_pat[PAT_W-1];
            valid_n = 1'b1;
            busy_n  = 1'b1;
          end else begin
            state_n = S_GAP;
            gcnt_n  = gap_q;
            busy_n  = 1'b1;
          end
        end else begin
          shreg_n = {shreg[PAT_W-2:0], 1'b0};
          idx_n   = bit_idx - 3'd1;
          out_n   = shreg[PAT_W-2];
          valid_n = 1'b1;
          busy_n  = 1'b1;
        end
      end

      S_GAP: begin
        if (abort) begin
          state_n = S_IDLE;
        end else if (gap_cnt == 4'd1) begin
          state_n = S_SHIFT;
          shreg_n = rom_pat;
          idx_n   = 3'd4;
          out_n   = rom_pat[PAT_W-1];
          valid_n = 1'b1;
          busy_n  = 1'b1;
        end else begin
          gcnt_n = gap_cnt - 4'd1;
          busy_n = 1'b1;
        end
      end

      S_DONE: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // State, datapath and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      pat_q        <= 2'b00;
      shreg        <= '0;
      bit_idx      <= '0;
      frame_cnt    <= '0;
      gap_q        <= '0;
      gap_cnt      <= '0;
      frames_sent  <= '0;
      serial_out   <= GAP_BIT;
      serial_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_n;
      pat_q        <= pat_n;
      shreg        <= shreg_n;
      bit_idx      <= idx_n;
      frame_cnt    <= frame_n;
      gap_q        <= gap_n;
      gap_cnt      <= gcnt_n;
      frames_sent  <= frames_n;
      serial_out   <= out_n;
      serial_valid <= valid_n;
      busy         <= busy_n;
      done         <= done_n;
    end
  end

endmodule

// File: tb/tb_pattern_sequence_generator.sv
// Self-checking bench for pattern_sequence_generator.
// Scoreboard of expected serial bits plus per-cycle timing model.
module tb_pattern_sequence_generator;

  localparam logic GAP_BIT = 1'b0;
  localparam int   CNT_W   = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             abort;
  logic [1:0]       pattern_sel;
  logic [7:0]       repeat_count;
  logic [3:0]       gap_len;
  logic             serial_out;
  logic             serial_valid;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] frames_sent;

  int checks = 0;
  int passed = 0;

  logic exp_q[$];
  int   fs_model = 0;
  logic [1:0] prev_sel = 2'b00;

  pattern_sequence_generator #(
    .GAP_BIT (GAP_BIT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .pattern_sel  (pattern_sel),
    .repeat_count (repeat_count),
    .gap_len      (gap_len),
    .serial_out   (serial_out),
    .serial_valid (serial_valid),
    .busy         (busy),
    .done         (done),
    .frames_sent  (frames_sent)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] pat_of(input logic [1:0] s);
    case (s)
      2'b00:   return 5'b10111;
      2'b01:   return 5'b01010;
      2'b10:   return 5'b10101;
      default: return 5'b10100;
    endcase
  endfunction

  task automatic push_bits(input logic [1:0] s, input int nbits);
    logic [4:0] p;
    p = pat_of(s);
    for (int i = 0; i < nbits; i++)
      exp_q.push_back(p[4 - (i % 5)]);
  endtask

  // Scoreboard: every valid bit must match the next expected bit
  always @(negedge clk) begin
    if (serial_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL bit_unexpected: got %b, required no valid bit",
                 serial_out);
      end else begin
        logic e;
        e = exp_q.pop_front();
        if (serial_out !== e)
          $display("FAIL serial_bit: got %b, required %b",
                   serial_out, e);
        else
          passed++;
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    pattern_sel = 2'b00; repeat_count = 8'd0; gap_len = 4'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({serial_out, serial_valid, busy, done} !== {GAP_BIT, 3'b000}
        || frames_sent !== '0)
      $display("FAIL reset_values: got out=%b v=%b b=%b d=%b fs=%0d, required %b 0 0 0 0",
               serial_out, serial_valid, busy, done, frames_sent, GAP_BIT);
    else
      passed++;
    reset = 1'b0;
    @(negedge clk);
    fs_model = 0; prev_sel = 2'b00;
  endtask

  // One full transfer; optional stray start pulse at cycle spam
  task automatic run_xfer(input logic [1:0] s, input int n,
                          input int g, input int spam);
    int last, done_at, period, fs_start;
    logic ev, eb, ed;
    last    = (n == 0) ? 0 : 5 * n + g * (n - 1);
    done_at = last + 1;
    period  = 5 + g;
    fs_start = (s != prev_sel) ? 0 : fs_model;
    prev_sel = s;
    fs_model = fs_start + n;
    if (fs_model > 65535) fs_model = 65535;
    push_bits(s, 5 * n);
    start = 1'b1; pattern_sel = s;
    repeat_count = n[7:0]; gap_len = g[3:0];
    for (int k = 1; k <= done_at + 1; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == spam) begin
        start = 1'b1; pattern_sel = ~s;
        repeat_count = 8'd7; gap_len = 4'd3;
      end
      ev = (k <= last) && (((k - 1) % period) < 5);
      eb = (k <= last);
      ed = (k == done_at);
      checks++;
      if (serial_valid !== ev || busy !== eb || done !== ed)
        $display("FAIL timing_s%0d_n%0d_c%0d: got v=%b b=%b d=%b, required v=%b b=%b d=%b",
                 s, n, k, serial_valid, busy, done, ev, eb, ed);
      else
        passed++;
      if (!ev) begin
        checks++;
        if (serial_out !== GAP_BIT)
          $display("FAIL idle_line_c%0d: got %b, required %b",
                   k, serial_out, GAP_BIT);
        else
          passed++;
      end
      if (k == 1) begin
        checks++;
        if (frames_sent !== fs_start[CNT_W-1:0])
          $display("FAIL frames_at_start: got %0d, required %0d",
                   frames_sent, fs_start);
        else
          passed++;
      end
    end
    start = 1'b0;
    checks++;
    if (frames_sent !== fs_model[CNT_W-1:0] || exp_q.size() != 0)
      $display("FAIL xfer_end_s%0d_n%0d: got fs=%0d left=%0d, required fs=%0d left=0",
               s, n, frames_sent, exp_q.size(), fs_model);
    else
      passed++;
  endtask

  task automatic test_single();
    run_xfer(2'b00, 1, 0, 0);
  endtask

  task automatic test_gap();
    run_xfer(2'b10, 3, 2, 0);
  endtask

  task automatic test_back_to_back();
    run_xfer(2'b01, 4, 0, 7);
  endtask

  task automatic test_abort();
    int abort_k, fs_start;
    logic ev;
    abort_k  = 5 + 1 + 3;
    fs_start = (prev_sel != 2'b10) ? 0 : fs_model;
    prev_sel = 2'b10;
    push_bits(2'b10, 8);
    start = 1'b1; pattern_sel = 2'b10;
    repeat_count = 8'd5; gap_len = 4'd1;
    for (int k = 1; k <= abort_k; k++) begin
      @(negedge clk);
      start = 1'b0;
      ev = ((k - 1) % 6) < 5;
      checks++;
      if (serial_valid !== ev || busy !== 1'b1)
        $display("FAIL abort_pre_c%0d: got v=%b b=%b, required v=%b b=1",
                 k, serial_valid, busy, ev);
      else
        passed++;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    fs_model = fs_start + 1;
    checks++;
    if (busy !== 1'b0 || serial_valid !== 1'b0 || done !== 1'b0
        || serial_out !== GAP_BIT || frames_sent !== fs_model[CNT_W-1:0])
      $display("FAIL abort_idle: got b=%b v=%b d=%b o=%b fs=%0d, required 0 0 0 %b %0d",
               busy, serial_valid, done, serial_out, frames_sent,
               GAP_BIT, fs_model);
    else
      passed++;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0)
        $display("FAIL abort_no_done: got d=%b b=%b, required 0 0",
                 done, busy);
      else
        passed++;
    end
    run_xfer(2'b10, 1, 0, 0);
  endtask

  task automatic test_pattern_change();
    run_xfer(2'b01, 2, 0, 0);
    run_xfer(2'b11, 3, 1, 0);
    run_xfer(2'b11, 0, 0, 1);
  endtask

  task automatic test_reset_mid_gap();
    push_bits(2'b10, 5);
    start = 1'b1; pattern_sel = 2'b10;
    repeat_count = 8'd3; gap_len = 4'd2;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 3) begin
        start = 1'b1; pattern_sel = 2'b00; repeat_count = 8'd1;
      end
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    fs_model = 0; prev_sel = 2'b00;
    checks++;
    if ({serial_out, serial_valid, busy, done} !== {GAP_BIT, 3'b000}
        || frames_sent !== '0 || exp_q.size() != 0)
      $display("FAIL reset_mid_gap: got o=%b v=%b b=%b d=%b fs=%0d left=%0d, required %b 0 0 0 0 0",
               serial_out, serial_valid, busy, done, frames_sent,
               exp_q.size(), GAP_BIT);
    else
      passed++;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || serial_valid !== 1'b0)
      $display("FAIL post_reset_idle: got b=%b v=%b, required 0 0",
               busy, serial_valid);
    else
      passed++;
    run_xfer(2'b00, 2, 1, 4);
  endtask

  initial begin
    test_reset();
    test_single();
    test_gap();
    test_back_to_back();
    test_abort();
    test_pattern_change();
    test_reset_mid_gap();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
